spm_seq_mult: RTL and testbench

Parametrised serial-parallel multiplier with valid/ready handshakes. It multiplies two WIDTH-bit operands through a row of WIDTH carry-save cells, serialising the y operand LSB-first and collecting the 2*WIDTH-bit product serially. It is the generalised successor of the fixed-size spm datapath, adding width parameterisation, a signed mode, and flow control. It sits between an operand producer and a result consumer, each with its own handshake.

---
 rtl/spm_seq_mult_if.sv | 25 ++
 rtl/spm_seq_mult.sv | 131 +++++++++++++
 tb/tb_spm_seq_mult.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/spm_seq_mult_if.sv
// Operand/result handshake bundle for the serial-parallel multiplier.
// master = operand producer + result consumer, slave = the multiplier.
interface spm_seq_mult_if #(
    parameter int WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_signed;
    logic [WIDTH-1:0]     in_x;
    logic [WIDTH-1:0]     in_y;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_p;
    logic                 busy;

    modport master (
        output in_valid, in_signed, in_x, in_y, out_ready,
        input  in_ready, out_valid, out_p, busy
    );

    modport slave (
        input  in_valid, in_signed, in_x, in_y, out_ready,
        output in_ready, out_valid, out_p, busy
    );
endinterface

// File: rtl/spm_seq_mult.sv
// Serial-parallel multiplier: a row of WIDTH carry-save cells consumes y LSB-first
// and emits one product bit per cycle over 2*WIDTH cycles; signed via magnitudes.
module spm_seq_mult #(
    parameter int WIDTH     = 32,
    parameter int SIGNED_EN = 1
) (
    input  logic          clk,
    input  logic          rst,
    spm_seq_mult_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(PW);
    localparam logic [CW-1:0] CNT_LAST = CW'(PW - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] xr_q, xr_d;
    logic [WIDTH-1:0] yr_q, yr_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [PW-3:0]    acc_q, acc_d;
    logic [PW-1:0]    out_p_q, out_p_d;

    logic [WIDTH-1:0] s_nxt;
    logic [WIDTH-1:0] c_nxt;
    logic [PW-1:0]    acc_fin;
    logic             ybit;
    logic             sgn;

    // yr shifts right each SHIFT cycle, so bit 0 is y[cnt] and reads 0 after WIDTH cycles.
    assign ybit = yr_q[0];

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        logic a;
        logic b;
        assign a = xr_q[gi] & ybit;
        if (gi == WIDTH - 1) begin : g_top
            assign b = 1'b0;
        end else begin : g_mid
            assign b = s_q[gi+1];
        end
        assign s_nxt[gi] = a ^ b ^ c_q[gi];
        assign c_nxt[gi] = (a & b) | (a & c_q[gi]) | (b & c_q[gi]);
    end

    // acc trails s[0] by one cycle, so the finished product is the fresh bit,
    // the previous bit still sitting in s[0], and the older bits in acc.
    assign acc_fin = {s_nxt[0], s_q[0], acc_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        xr_d    = xr_q;
        yr_d    = yr_q;
        neg_d   = neg_q;
        s_d     = s_q;
        c_d     = c_q;
        acc_d   = acc_q;
        out_p_d = out_p_q;
        sgn     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    sgn     = bus.in_signed && (SIGNED_EN != 0);
                    xr_d    = (sgn && bus.in_x[WIDTH-1]) ? (~bus.in_x + WIDTH'(1)) : bus.in_x;
                    yr_d    = (sgn && bus.in_y[WIDTH-1]) ? (~bus.in_y + WIDTH'(1)) : bus.in_y;
                    neg_d   = sgn && (bus.in_x[WIDTH-1] ^ bus.in_y[WIDTH-1]);
                    s_d     = '0;
                    c_d     = '0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                s_d   = s_nxt;
                c_d   = c_nxt;
                acc_d = {s_q[0], acc_q[PW-3:1]};
                yr_d  = yr_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    out_p_d = neg_q ? (~acc_fin + PW'(1)) : acc_fin;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            xr_q    <= '0;
            yr_q    <= '0;
            neg_q   <= 1'b0;
            s_q     <= '0;
            c_q     <= '0;
            acc_q   <= '0;
            out_p_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            neg_q   <= neg_d;
            s_q     <= s_d;
            c_q     <= c_d;
            acc_q   <= acc_d;
            out_p_q <= out_p_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q == ST_SHIFT);
    assign bus.out_p     = out_p_q;
endmodule

// File: tb/tb_spm_seq_mult.sv
// Directed bench for spm_seq_mult at WIDTH=8: latency, signed mode, backpressure,
// asynchronous reset mid-operation and back-to-back throughput.
module tb_spm_seq_mult;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spm_seq_mult_if #(.WIDTH(8)) bus ();
    spm_seq_mult_if #(.WIDTH(8)) bus_u ();

    spm_seq_mult #(.WIDTH(8), .SIGNED_EN(1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    spm_seq_mult #(.WIDTH(8), .SIGNED_EN(0)) dut_u (
        .clk(clk),
        .rst(rst),
        .bus(bus_u)
    );

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One operation on the signed-enabled instance; operands are scrambled after accept.
    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic sg,
                          output logic [15:0] p, output int lat, output int busy_n);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        bus.in_x      = x;
        bus.in_y      = y;
        bus.in_signed = sg;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in_x      = 8'($urandom);
        bus.in_y      = 8'($urandom);
        bus.in_signed = ~sg;
        lat    = 1;
        busy_n = 0;
        while (!bus.out_valid && lat < 100) begin
            if (bus.busy) busy_n++;
            @(negedge clk);
            lat++;
        end
        p = bus.out_p;
        $display("op x=%h y=%h signed=%0d -> p=%h latency=%0d busy=%0d", x, y, sg, p, lat, busy_n);
    endtask

    logic [15:0] p;
    int          lat;
    int          busy_n;
    int          guard;
    int          prev_cyc;
    logic [7:0]  bx [4];
    logic [7:0]  by [4];
    logic [15:0] bp [4];

    initial begin
        bx = '{8'h5A, 8'hE7, 8'h9D, 8'h0F};
        by = '{8'h3C, 8'h19, 8'hB2, 8'hF0};
        bp = '{16'h1518, 16'h168F, 16'h6D2A, 16'h0E10};

        bus.in_valid = 1'b0; bus.in_signed = 1'b0; bus.in_x = '0; bus.in_y = '0; bus.out_ready = 1'b1;
        bus_u.in_valid = 1'b0; bus_u.in_signed = 1'b0; bus_u.in_x = '0; bus_u.in_y = '0; bus_u.out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  bus.in_ready,  1'b1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_busy",      bus.busy,      1'b0);
        chk("rst_out_p",     bus.out_p,     16'h0000);
        rst = 1'b1;

        // Unsigned max operands, latency and busy width
        run_op(8'hFF, 8'hFF, 1'b0, p, lat, busy_n);
        chk("ff_ff_p",      p,      16'hFE01);
        chk("ff_ff_lat",    lat,    17);
        chk("ff_ff_busy",   busy_n, 16);
        chk("ff_ff_carry0", dut.c_q, 8'h00);

        // Signed mode
        run_op(8'h80, 8'h80, 1'b1, p, lat, busy_n);
        chk("s_80_80", p, 16'h4000);
        run_op(8'hFF, 8'h03, 1'b1, p, lat, busy_n);
        chk("s_ff_03", p, 16'hFFFD);
        run_op(8'h7F, 8'h81, 1'b1, p, lat, busy_n);
        chk("s_7f_81", p, 16'hC0FF);

        // SIGNED_EN=0 instance ignores in_signed
        @(negedge clk);
        bus_u.in_x = 8'hFF; bus_u.in_y = 8'h03; bus_u.in_signed = 1'b1; bus_u.in_valid = 1'b1;
        @(negedge clk);
        bus_u.in_valid = 1'b0;
        guard = 1;
        while (!bus_u.out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        $display("op(unsigned-only) x=ff y=03 signed=1 -> p=%h latency=%0d", bus_u.out_p, guard);
        chk("u_ff_03",     bus_u.out_p, 16'h02FD);
        chk("u_ff_03_lat", guard,       17);

        // Backpressure: result and flags hold while out_ready is low, in_valid ignored
        bus.out_ready = 1'b0;
        run_op(8'h12, 8'h34, 1'b0, p, lat, busy_n);
        chk("bp_p", p, 16'h03A8);
        bus.in_valid = 1'b1; bus.in_x = 8'h77; bus.in_y = 8'h66;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold", {bus.out_valid, bus.in_ready, bus.out_p}, {1'b1, 1'b0, 16'h03A8});
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", {bus.out_valid, bus.in_ready, bus.busy}, {1'b0, 1'b1, 1'b0});
        chk("bp_p_kept",  bus.out_p, 16'h03A8);

        // Asynchronous reset at cnt=5
        bus.in_x = 8'hAA; bus.in_y = 8'h55; bus.in_signed = 1'b0; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_busy_before", bus.busy, 1'b1);
        rst = 1'b0;
        #1;
        chk("mid_rst_flags", {bus.in_ready, bus.out_valid, bus.busy}, {1'b1, 1'b0, 1'b0});
        chk("mid_rst_out_p", bus.out_p, 16'h0000);
        chk("mid_rst_acc",   dut.acc_q, 14'h0000);
        @(negedge clk);
        rst = 1'b1;
        run_op(8'h03, 8'h05, 1'b0, p, lat, busy_n);
        chk("after_rst_p",   p,   16'h000F);
        chk("after_rst_lat", lat, 17);

        // Back-to-back with in_valid and out_ready held high
        @(negedge clk);
        bus.in_x = bx[0]; bus.in_y = by[0]; bus.in_signed = 1'b0; bus.in_valid = 1'b1;
        prev_cyc = 0;
        for (int i = 0; i < 4; i++) begin
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (!bus.out_valid && guard < 60);
            $display("b2b x=%h y=%h -> p=%h at cycle %0d", bx[i], by[i], bus.out_p, cyc);
            chk("b2b_p",   bus.out_p, bp[i]);
            chk("b2b_sc0", {dut.s_q, dut.c_q}, 16'h0000);
            if (i > 0) chk("b2b_spacing", cyc - prev_cyc, 18);
            prev_cyc = cyc;
            if (i < 3) begin
                bus.in_x = bx[i+1];
                bus.in_y = by[i+1];
            end else begin
                bus.in_valid = 1'b0;
            end
        end

        // Zero and identity
        run_op(8'h00, 8'hC3, 1'b0, p, lat, busy_n);
        chk("zero",   p, 16'h0000);
        run_op(8'h01, 8'hC3, 1'b0, p, lat, busy_n);
        chk("id_u",   p, 16'h00C3);
        run_op(8'h01, 8'hC3, 1'b1, p, lat, busy_n);
        chk("id_s",   p, 16'hFFC3);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
